color_bar_generator: RTL
========================

// Module: color_bar_generator
// PURPOSE
// - Test-pattern video source feeding hdmi_source: eight vertical colour bars, 8 pixels/beat, ready/valid stream.
// - Frame starts on hdmi_source's start_frame pulse; runs in the TMDS (tx) clock domain beside the HDMI top level.
// PARAMETERS
// - BAR_LEVEL     8'hC0  component level for lit colour-bar channels (0x00 for unlit)
// - COORD_WIDTH   16     width of video_width/video_height and internal x/y counters
// PORTS
// - clock         in   1    tx clock; single clock domain
// - reset         in   1    synchronous, active-high
// - video_width   in   16   active pixels per line; must be a multiple of 64
// - video_height  in   16   active lines per frame
// - start_frame   in   1    one-cycle pulse: begin a new frame at pixel (0,0)
// - ready         in   1    consumer accepts beat when valid & ready
// - valid         out  1    beat on bits_* is valid
// - bits_0..3     out  64   bits_k = {8'h00,RGB(px 2k+1), 8'h00,RGB(px 2k)}; RGB = {R,G,B}
// - busy          out  1    frame in progress (beats remaining)
// BEHAVIOUR
// - Interface: one clock, synchronous active-high reset; ports clock and reset.
// - Reset: valid=0, bits_*=0, busy=0, x/y/bar counters=0. Reset mid-frame aborts; valid low from next cycle.
// - start_frame (cycle N): latch width/height; beats_per_line=width[15:3], beats_per_bar=width[15:6].
//   valid=1 with beat (x=0,y=0) at cycle N+1; busy=1 from N+1.
// - Skid-free register stage: output regs load when (~valid | ready); bits_* stable while valid & ~ready.
// - Beat order: x beat 0..beats_per_line-1, then y+1; all 8 pixels of a beat share one bar.
// - Bar index 0..7 advances every beats_per_bar beats, resets at line start. Colours:
//   0 white, 1 yellow, 2 cyan, 3 green, 4 magenta, 5 red, 6 blue, 7 black (lit channel = BAR_LEVEL).
// - After last beat (x=last, y=height-1) accepted: valid=0, busy=0 next cycle; idle until start_frame.
// - start_frame while busy: remainder dropped; next presented beat is (0,0) regardless of ready.
// - start_frame same cycle as last-beat handshake: new frame wins, beat (0,0) follows.
// - width<64 or height==0 at start_frame: ignored; valid and busy stay 0.
// - Counters are COORD_WIDTH wide, no wrap inside legal frame; width not multiple of 64: undefined colours, beat count still width[15:3].
// CONFIGURATION
// - GRADIENT_OVERLAY_EN defined: lines y >= height-(height>>2) output grey ramp, pixel x: R=G=B=x[7:0] (wraps every 256 px).
// - GRADIENT_OVERLAY_EN undefined: bars on every line; ramp logic absent.
// STRUCTURE
// - Package hdmi_video_pkg: PIXELS_PER_BEAT=8, bar colour index constants, pack_pixel(rgb) → 32-bit function.
// - Sub-module bar_color_lut: combinational 3-bit index + BAR_LEVEL → 24-bit RGB.
// - Top: frame FSM IDLE/ACTIVE, x/y/bar counters, output register stage.
// TESTING
// - 64x2, ready=1: start_frame → 16 beats; beat0 bits_0=64'h00C0C0C0_00C0C0C0, beat1 bits_0=64'h00C0C000_00C0C000; valid=0 after beat 16.
// - 64x2, ready random 50%: bits_* unchanged during every valid&~ready cycle; exactly 16 accepted beats, same sequence.
// - 1920x1080: bar switches every 30 beats; beats per frame = 259200; busy falls one cycle after last accept.
// - start_frame after 5th accept of 64x2 frame → next beat white (0,0); total accepts after restart = 16.
// - height=0 start_frame → valid,busy stay 0 for 100 cycles; reset mid-frame → valid=0 next cycle, no beats until start_frame.
// - GRADIENT_OVERLAY_EN, 64x4: line 3 beat0 bits_0=64'h00010101_00000000, bits_3=64'h00070707_00060606; lines 0-2 bars.

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// hdmi_video_pkg: shared constants, frame state type and pixel packing for the colour-bar source.
// Contents: PIXELS_PER_BEAT, NUM_BARS, MIN_WIDTH, bar colour indices, frame_state_t, pack_pixel().
package hdmi_video_pkg;
    localparam int PIXELS_PER_BEAT = 8;
    localparam int NUM_BARS = 8;
    // Narrowest legal line: every bar at least one beat wide
    localparam int MIN_WIDTH = PIXELS_PER_BEAT * NUM_BARS;
    localparam logic [2:0] BAR_WHITE   = 3'd0;
    localparam logic [2:0] BAR_YELLOW  = 3'd1;
    localparam logic [2:0] BAR_CYAN    = 3'd2;
    localparam logic [2:0] BAR_GREEN   = 3'd3;
    localparam logic [2:0] BAR_MAGENTA = 3'd4;
    localparam logic [2:0] BAR_RED     = 3'd5;
    localparam logic [2:0] BAR_BLUE    = 3'd6;
    localparam logic [2:0] BAR_BLACK   = 3'd7;
    typedef enum logic {IDLE, ACTIVE} frame_state_t;
    // One pixel occupies a 32-bit lane: zero pad byte above {R,G,B}
    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
        return {8'h00, rgb};
    endfunction
endpackage

// File: rtl/bar_color_lut.sv
// bar_color_lut: combinational bar index to 24-bit {R,G,B} colour.
// Ports: idx (in, 3) bar index 0..7; rgb (out, 24) colour, lit channels at BAR_LEVEL.
module bar_color_lut
    import hdmi_video_pkg::*;
#(
    parameter logic [7:0] BAR_LEVEL = 8'hC0
) (
    input  logic [2:0]  idx,
    output logic [23:0] rgb
);
    localparam logic [7:0] L = BAR_LEVEL;
    always_comb begin
        rgb = '0;
        case (idx)
            BAR_WHITE:   rgb = {L, L, L};
            BAR_YELLOW:  rgb = {L, L, 8'h00};
            BAR_CYAN:    rgb = {8'h00, L, L};
            BAR_GREEN:   rgb = {8'h00, L, 8'h00};
            BAR_MAGENTA: rgb = {L, 8'h00, L};
            BAR_RED:     rgb = {L, 8'h00, 8'h00};
            BAR_BLUE:    rgb = {8'h00, 8'h00, L};
            default:     rgb = '0;
        endcase
    end
endmodule

// File: rtl/color_bar_generator.sv
// color_bar_generator: eight-bar video test pattern, 8 pixels per beat on a ready/valid stream.
// Ports: clock, reset (sync, active-high); video_width, video_height (in, COORD_WIDTH) frame size;
//   start_frame (in) pulse to begin a frame at (0,0); ready (in) consumer accept;
//   valid (out) beat present; bits_0..bits_3 (out, 64) two packed pixels each; busy (out) frame in progress.
// Build option: define GRADIENT_OVERLAY_EN to replace the bottom quarter of lines with a grey ramp.
module color_bar_generator
    import hdmi_video_pkg::*;
#(
    parameter logic [7:0] BAR_LEVEL   = 8'hC0,
    parameter int         COORD_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COORD_WIDTH-1:0] video_width,
    input  logic [COORD_WIDTH-1:0] video_height,
    input  logic                   start_frame,
    input  logic                   ready,
    output logic                   valid,
    output logic [63:0]            bits_0,
    output logic [63:0]            bits_1,
    output logic [63:0]            bits_2,
    output logic [63:0]            bits_3,
    output logic                   busy
);
    localparam int CW = COORD_WIDTH;
    frame_state_t state;
    logic [CW-1:0] x, y, bar_cnt, bpl, bpb, height, nx, ny, nbar_cnt;
    logic [2:0] bar, nbar, sel_bar;
    logic start_ok, line_end, bar_end, last;
    logic [23:0] rgb;
    logic [63:0] beat [4];
    assign start_ok = start_frame && video_width >= CW'(MIN_WIDTH) && video_height != '0;
    assign line_end = x == bpl - CW'(1);
    assign bar_end  = bar_cnt == bpb - CW'(1);
    assign last     = line_end && y == height - CW'(1);
    // Coordinates of the beat that follows the one currently presented
    assign nx       = line_end ? '0 : x + CW'(1);
    assign ny       = line_end ? y + CW'(1) : y;
    assign nbar_cnt = (line_end || bar_end) ? '0 : bar_cnt + CW'(1);
    assign nbar     = line_end ? BAR_WHITE : bar_end ? bar + 3'd1 : bar;
    // A new frame always loads beat (0,0), overriding any in-flight advance
    assign sel_bar  = start_ok ? BAR_WHITE : nbar;
    bar_color_lut #(.BAR_LEVEL(BAR_LEVEL)) lut (.idx(sel_bar), .rgb(rgb));
`ifdef GRADIENT_OVERLAY_EN
    logic [CW-1:0] sel_y, sel_h;
    logic [4:0] sel_xl;
    logic ramp;
    assign sel_y  = start_ok ? '0 : ny;
    assign sel_h  = start_ok ? video_height : height;
    assign sel_xl = start_ok ? '0 : nx[4:0];
    assign ramp   = sel_y >= sel_h - (sel_h >> 2);
`endif
    always_comb begin
        for (int k = 0; k < 4; k++) begin
`ifdef GRADIENT_OVERLAY_EN
            // Ramp level is the low byte of the pixel x coordinate, beat*8 + lane
            beat[k] = ramp ? {pack_pixel({3{sel_xl, 3'(2*k+1)}}), pack_pixel({3{sel_xl, 3'(2*k)}})}
                           : {pack_pixel(rgb), pack_pixel(rgb)};
`else
            beat[k] = {pack_pixel(rgb), pack_pixel(rgb)};
`endif
        end
    end
    // valid is high throughout ACTIVE, so ready alone marks a handshake there
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            x       <= '0;
            y       <= '0;
            bar     <= '0;
            bar_cnt <= '0;
            bpl     <= '0;
            bpb     <= '0;
            height  <= '0;
            bits_0  <= '0;
            bits_1  <= '0;
            bits_2  <= '0;
            bits_3  <= '0;
        end else if (start_ok) begin
            state   <= ACTIVE;
            valid   <= 1'b1;
            busy    <= 1'b1;
            bpl     <= video_width >> $clog2(PIXELS_PER_BEAT);
            bpb     <= video_width >> $clog2(MIN_WIDTH);
            height  <= video_height;
            x       <= '0;
            y       <= '0;
            bar     <= '0;
            bar_cnt <= '0;
            bits_0  <= beat[0];
            bits_1  <= beat[1];
            bits_2  <= beat[2];
            bits_3  <= beat[3];
        end else if (state == ACTIVE && ready) begin
            if (last) begin
                state <= IDLE;
                valid <= 1'b0;
                busy  <= 1'b0;
            end else begin
                x       <= nx;
                y       <= ny;
                bar     <= nbar;
                bar_cnt <= nbar_cnt;
                bits_0  <= beat[0];
                bits_1  <= beat[1];
                bits_2  <= beat[2];
                bits_3  <= beat[3];
            end
        end
    end
endmodule
